// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, DM_BUSY, IF_BUSY)
//   gnt_owner_e : which requester owns the memory port (GntIf, GntDm)
package MemArbCtrl;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DM_BUSY = 2'd1,
    IF_BUSY = 2'd2
  } arb_state_e;

  typedef enum logic {
    GntIf = 1'b0,
    GntDm = 1'b1
  } gnt_owner_e;

endpackage

// File: rtl/mem_port_arbiter_grant.sv
// mem_arb_grant: arbitration decision between fetch and data-stage requests.
// Ports:
//   if_req   in  fetch request
//   dm_req   in  data-stage request
//   last_gnt in  owner of the most recent grant
//   gnt      out owner to grant this cycle (only meaningful when a request is up)
// On a collision the requester not granted last wins. Feeding a constant
// GntIf for last_gnt turns this into fixed data-stage priority.
import MemArbCtrl::*;

module mem_arb_grant (
  input  logic       if_req,
  input  logic       dm_req,
  input  gnt_owner_e last_gnt,
  output gnt_owner_e gnt
);

  always_comb begin
    gnt = GntIf;
    if (if_req && dm_req) begin
      gnt = (last_gnt == GntIf) ? GntDm : GntIf;
    end else if (dm_req) begin
      gnt = GntDm;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified memory port between the fetch stage
// and the data-memory stage.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   if_req/if_addr                 fetch request and address
//   if_rdata/if_ready              fetch read data and done pulse
//   dm_req/dm_we/dm_addr/dm_wdata  data-stage request
//   dm_rdata/dm_ready              data-stage read data and done pulse
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request
//   mem_rdata/mem_ack              memory read data and single-cycle completion
//   stall_fetch/stall_mem          stall indications to the hazard unit
// Build option: MEM_ARB_RR_EN -- when defined, collisions are resolved
// round-robin using a last-grant register; otherwise data stage always wins.
//
// state   | meaning
// IDLE    | port free, mem_req low, next request is granted here
// DM_BUSY | data-stage transaction outstanding, waiting for mem_ack
// IF_BUSY | fetch transaction outstanding, waiting for mem_ack
import MemArbCtrl::*;

module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_fetch,
  output logic        stall_mem
);

  arb_state_e state_q;
  gnt_owner_e gnt;
  gnt_owner_e last_gnt;
  logic       any_req;

  assign any_req = if_req || dm_req;

  mem_arb_grant u_grant (
    .if_req   (if_req),
    .dm_req   (dm_req),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

`ifdef MEM_ARB_RR_EN
  gnt_owner_e last_gnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= GntIf;
    end else if (state_q == IDLE && any_req) begin
      last_gnt_q <= gnt;
    end
  end

  assign last_gnt = last_gnt_q;
`else
  // Constant "fetch was last" makes the grant block prefer the data stage.
  assign last_gnt = GntIf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // mem_ack is deliberately ignored here; stray acks do nothing.
          if (any_req) begin
            mem_req <= 1'b1;
            if (gnt == GntDm) begin
              state_q   <= DM_BUSY;
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end else begin
              state_q   <= IF_BUSY;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end
        end
        DM_BUSY, IF_BUSY: begin
          // Requester inputs are not sampled while busy; the bus holds.
          if (mem_ack) begin
            state_q   <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Ready must coincide with the ack cycle, so it is decoded from state.
  assign dm_ready    = (state_q == DM_BUSY) && mem_ack;
  assign if_ready    = (state_q == IF_BUSY) && mem_ack;
  assign dm_rdata    = dm_ready ? mem_rdata : '0;
  assign if_rdata    = if_ready ? mem_rdata : '0;
  assign stall_fetch = if_req && !if_ready;
  assign stall_mem   = dm_req && !dm_ready;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have: if_req in 1 fetch request; if_addr in 32 fetch address; if_rdata out 32 fetch data; if_ready out 1 fetch done pulse.
REQ-004 SHALL have: dm_req in 1 data-stage request; dm_we in 1 write enable; dm_addr in 32; dm_wdata in 32; dm_rdata out 32; dm_ready out 1 data done pulse.
REQ-005 SHALL have: mem_req out 1; mem_we out 1; mem_addr out 32; mem_wdata out 32; mem_rdata in 32; mem_ack in 1 single-cycle completion from the unified memory.
REQ-006 SHALL have: stall_fetch out 1; stall_mem out 1, both feeding the pipeline hazard unit.

Function
REQ-007 SHALL implement FSM with states IDLE, DM_BUSY and IF_BUSY; reset state IDLE.
REQ-008 In IDLE with any request, SHALL grant one requester, register mem_we/mem_addr/mem_wdata from it, assert mem_req from the next cycle, and enter the matching BUSY state.
REQ-009 Default priority (macro absent): dm_req beats if_req when both are high in IDLE.
REQ-010 In a BUSY state, mem_req and the mem_* address/data SHALL stay constant until mem_ack.
REQ-011 On the mem_ack cycle, SHALL pulse the owner's ready for exactly that cycle; x_rdata = mem_rdata in that cycle only, otherwise 0.
REQ-012 The cycle after mem_ack, SHALL be in IDLE with mem_req=0. Minimum turnaround is one idle bus cycle, so back-to-back transactions issue every ack+2 cycles.
REQ-013 mem_we SHALL be 0 for fetch grants and dm_we for data grants; mem_wdata SHALL be 0 for fetch grants.
REQ-014 SHALL ignore mem_ack in IDLE, with no ready pulse and no state change.
REQ-015 stall_fetch = if_req && !if_ready; stall_mem = dm_req && !dm_ready (combinational).
REQ-016 A request still high in the cycle after its ready SHALL be treated as a new request.
REQ-017 SHALL ignore requester input changes during BUSY. Requesters hold them stable while stalled.

Reset
REQ-018 On rst_n low: state IDLE; mem_req, mem_we, mem_addr, mem_wdata = 0; if_ready, dm_ready = 0; rdata outputs 0; last-grant flag = IF.
REQ-019 Reset mid-transaction SHALL abandon it. A late mem_ack after reset release falls under REQ-014.

Configuration
REQ-020 Macro MEM_ARB_RR_EN: when defined, simultaneous requests in IDLE SHALL be granted round-robin (grant the requester not granted last; the last-grant flag updates on every grant). When undefined, fixed data priority per REQ-009 and no last-grant register.

Structure
REQ-021 Package MemArbCtrl SHALL hold the FSM state enum (IDLE, DM_BUSY, IF_BUSY) and the grant-owner enum (GntIf, GntDm).
REQ-022 Arbitration decision SHALL be one sub-module, mem_arb_grant (inputs: two requests, last grant; output: grant owner). FSM and datapath registers SHALL stay in mem_port_arbiter.

Verification
REQ-023 Fetch only: if_req=1, if_addr=0x0040_0000, ack 3 cycles after mem_req -> mem_addr=0x0040_0000, mem_we=0, if_ready pulse with if_rdata=mem_rdata=0x2008_0005, stall_fetch high until then.
REQ-024 Collision, macro off: if_req and dm_req rise together, dm_we=1, dm_addr=0x1001_0004, dm_wdata=0xDEAD_BEEF -> data served first (mem_we=1). Fetch issued 2 cycles after data ack; stall_fetch high throughout.
REQ-025 Collision, MEM_ARB_RR_EN defined: both requests held for 4 transactions -> grant order DM, IF, DM, IF.
REQ-026 Stray ack: mem_ack=1 while IDLE with no requests -> no ready pulse, state stays IDLE, mem_req=0.
REQ-027 Reset mid-op: rst_n low during DM_BUSY before ack -> mem_req=0 immediately. mem_ack one cycle after release -> no dm_ready.
REQ-028 Hold check: change dm_addr during DM_BUSY -> mem_addr unchanged until ack.
